regbank_wb_queue: RTL and testbench

Writeback queue sitting directly upstream of the register bank. It accepts register-write results from two producers, the ALU/execute path and the load/memory path, and buffers them in an in-order FIFO. It retires at most one write per cycle onto the bank's single write port (wr_en/wr_addr/wr_data → RegW/Rd/wrData). It also exports a pending-write scoreboard so decode can stall on RAW hazards against queued results.

---
 rtl/regbank_wb_queue_pkg.sv | 20 ++
 rtl/regbank_wb_queue_if.sv | 37 +++
 rtl/regbank_wb_queue_wb_fifo.sv | 65 ++++++
 rtl/regbank_wb_queue.sv | 91 +++++++++
 tb/tb_regbank_wb_queue.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/regbank_wb_queue_pkg.sv
`default_nettype none
// ============================================================================
// regbank_wb_queue_pkg -- shared register-file constants and queue entry type
// Revision 1.0
// ============================================================================
package regbank_wb_queue_pkg;

   localparam int NREG     = 17;
   localparam int SP_IDX   = 16;
   localparam int ZERO_IDX = 0;
   localparam int WB_AW    = 5;
   localparam int WB_DW    = 32;

   typedef struct packed {
      logic [WB_AW-1:0] addr;
      logic [WB_DW-1:0] data;
   } wb_entry_t;

endpackage : regbank_wb_queue_pkg
`default_nettype wire

// File: rtl/regbank_wb_queue_if.sv
`default_nettype none
// ============================================================================
// regbank_wb_queue_if -- producer intake, bank write port and scoreboard bus
// Revision 1.0
// ============================================================================
interface regbank_wb_queue_if #(
   parameter int AW   = 5,
   parameter int DW   = 32,
   parameter int NREG = 17,
   parameter int CW   = 3
);
   logic          alu_valid;
   logic [AW-1:0] alu_addr;
   logic [DW-1:0] alu_data;
   logic          alu_ready;
   logic          ld_valid;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_data;
   logic          ld_ready;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [NREG-1:0] busy;
   logic [CW-1:0] count;
   logic          err;

   modport master (
      output alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
      input  alu_ready, ld_ready, wr_en, wr_addr, wr_data, busy, count, err
   );

   modport slave (
      input  alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
      output alu_ready, ld_ready, wr_en, wr_addr, wr_data, busy, count, err
   );
endinterface : regbank_wb_queue_if
`default_nettype wire

// File: rtl/regbank_wb_queue_wb_fifo.sv
`default_nettype none
// ============================================================================
// wb_fifo -- DEPTH-entry in-order FIFO, 0/1/2 pushes and 0/1 pop per cycle
// Revision 1.0
// ============================================================================
module wb_fifo
   import regbank_wb_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  wire logic                     clk,
   input  wire logic                     reset,
   input  wire logic                     push0_i,
   input  wire wb_entry_t                push0_entry_i,
   input  wire logic                     push1_i,
   input  wire wb_entry_t                push1_entry_i,
   input  wire logic                     pop_i,
   output wb_entry_t                     head_o,
   output logic [$clog2(DEPTH):0]        count_o,
   output logic [DEPTH-1:0]              valid_o,
   output wb_entry_t [DEPTH-1:0]         entries_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   wb_entry_t [DEPTH-1:0] mem_q;
   logic [PW-1:0]         wr_ptr_q;
   logic [PW-1:0]         rd_ptr_q;
   logic [CW-1:0]         count_q;
   logic [PW-1:0]         off;

   // push1 is only ever raised together with push0, so it lands one slot later
   always_ff @(posedge clk) begin
      if (push0_i) mem_q[wr_ptr_q]           <= push0_entry_i;
      if (push1_i) mem_q[wr_ptr_q + PW'(1)]  <= push1_entry_i;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_q + PW'(push0_i) + PW'(push1_i);
         rd_ptr_q <= rd_ptr_q + PW'(pop_i);
         count_q  <= count_q + CW'(push0_i) + CW'(push1_i) - CW'(pop_i);
      end
   end

   // A slot is live when its distance from the head is below the occupancy
   always_comb begin
      off     = '0;
      valid_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off        = PW'(i) - rd_ptr_q;
         valid_o[i] = (CW'(off) < count_q);
      end
   end

   assign head_o    = mem_q[rd_ptr_q];
   assign count_o   = count_q;
   assign entries_o = mem_q;

endmodule : wb_fifo
`default_nettype wire

// File: rtl/regbank_wb_queue.sv
`default_nettype none
// ============================================================================
// regbank_wb_queue -- ALU/load writeback queue with RAW scoreboard for decode
// Revision 1.0
// ============================================================================
module regbank_wb_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 5,
   parameter int DW    = 32,
   parameter int NREG  = 17
) (
   input  wire logic         clk,
   input  wire logic         reset,
   regbank_wb_queue_if.slave bus
);
   import regbank_wb_queue_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;

   wb_entry_t             ld_ent, alu_ent, push0_entry, head;
   wb_entry_t [DEPTH-1:0] entries;
   logic [DEPTH-1:0]      valid;
   logic [CW-1:0]         count, free;
   logic                  ld_acc, alu_acc, ld_keep, alu_keep;
   logic                  push0, push1, pop;
   logic                  err_q, err_d;
   logic [NREG-1:0]       busy;

   assign free          = CW'(DEPTH) - count;
   assign bus.ld_ready  = (free != '0);
   assign bus.alu_ready = (free >= CW'(2)) || ((free == CW'(1)) && !bus.ld_valid);

   assign ld_acc   = bus.ld_valid  && bus.ld_ready;
   assign alu_acc  = bus.alu_valid && bus.alu_ready;
   assign ld_keep  = ld_acc  && (int'(bus.ld_addr)  != ZERO_IDX) && (int'(bus.ld_addr)  < NREG);
   assign alu_keep = alu_acc && (int'(bus.alu_addr) != ZERO_IDX) && (int'(bus.alu_addr) < NREG);

   assign ld_ent  = '{addr: WB_AW'(bus.ld_addr),  data: WB_DW'(bus.ld_data)};
   assign alu_ent = '{addr: WB_AW'(bus.alu_addr), data: WB_DW'(bus.alu_data)};

   // The load belongs to the older instruction, so it takes the first slot
   assign push0       = ld_keep || alu_keep;
   assign push0_entry = ld_keep ? ld_ent : alu_ent;
   assign push1       = ld_keep && alu_keep;

   // Held off during reset so a flushed head never reaches the bank
   assign pop = (count != '0) && !reset;

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk           (clk),
      .reset         (reset),
      .push0_i       (push0),
      .push0_entry_i (push0_entry),
      .push1_i       (push1),
      .push1_entry_i (alu_ent),
      .pop_i         (pop),
      .head_o        (head),
      .count_o       (count),
      .valid_o       (valid),
      .entries_o     (entries)
   );

   assign bus.wr_en   = pop;
   assign bus.wr_addr = (count != '0) ? AW'(head.addr) : '0;
   assign bus.wr_data = (count != '0) ? DW'(head.data) : '0;
   assign bus.count   = count;

   always_comb begin
      busy = '0;
      for (int r = 0; r < NREG; r++) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (int'(entries[i].addr) == r)) busy[r] = 1'b1;
         end
      end
   end
   assign bus.busy = busy;

   always_comb begin
      err_d = err_q;
      if (ld_acc  && (int'(bus.ld_addr)  >= NREG)) err_d = 1'b1;
      if (alu_acc && (int'(bus.alu_addr) >= NREG)) err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) err_q <= 1'b0;
      else       err_q <= err_d;
   end
   assign bus.err = err_q;

endmodule : regbank_wb_queue
`default_nettype wire

// File: tb/tb_regbank_wb_queue.sv
`default_nettype none
// ============================================================================
// tb_regbank_wb_queue -- directed vector table, reset flush and random vs model
// Revision 1.0
// ============================================================================
module tb_regbank_wb_queue;
   localparam int DEPTH = 4;
   localparam int NR    = 17;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   regbank_wb_queue_if #(.AW(5), .DW(32), .NREG(NR), .CW(3)) bus ();

   regbank_wb_queue #(.DEPTH(DEPTH), .AW(5), .DW(32), .NREG(NR)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        ldv;  logic [4:0] lda; logic [31:0] ldd;
      logic        alv;  logic [4:0] ala; logic [31:0] ald;
      logic        ldr;  logic       alr; logic        wr;
      logic [4:0]  wa;   logic [31:0] wd; logic [16:0] busy;
      logic [2:0]  cnt;  logic       err;
   } vec_t;

   typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
   ent_t mq[$];
   logic m_err = 1'b0;

   logic c_ldv, c_alv, c_rst;
   logic [4:0] c_lda, c_ala;
   logic [31:0] c_ldd, c_ald;

   function automatic vec_t mk(logic ldv, logic [4:0] lda, logic [31:0] ldd,
                               logic alv, logic [4:0] ala, logic [31:0] ald,
                               logic ldr, logic alr, logic wr, logic [4:0] wa,
                               logic [31:0] wd, logic [16:0] busy, logic [2:0] cnt,
                               logic err);
      vec_t v;
      v.ldv = ldv; v.lda = lda; v.ldd = ldd; v.alv = alv; v.ala = ala; v.ald = ald;
      v.ldr = ldr; v.alr = alr; v.wr = wr; v.wa = wa; v.wd = wd; v.busy = busy;
      v.cnt = cnt; v.err = err;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic ldv, input logic [4:0] lda, input logic [31:0] ldd,
                        input logic alv, input logic [4:0] ala, input logic [31:0] ald,
                        input logic rs);
      @(negedge clk);
      bus.ld_valid = ldv;  bus.ld_addr = lda;  bus.ld_data = ldd;
      bus.alu_valid = alv; bus.alu_addr = ala; bus.alu_data = ald;
      reset = rs;
      c_ldv = ldv; c_lda = lda; c_ldd = ldd; c_alv = alv; c_ala = ala; c_ald = ald; c_rst = rs;
      #1;
   endtask

   // Queue-level model: pop the head, then append accepted load, then ALU
   task automatic commit();
      int   free;
      logic lr, ar;
      @(posedge clk);
      free = DEPTH - mq.size();
      lr = (free >= 1);
      ar = (free >= 2) || (free == 1 && !c_ldv);
      if (c_rst) begin
         mq.delete();
         m_err = 1'b0;
      end else begin
         if (mq.size() > 0) void'(mq.pop_front());
         if (c_ldv && lr) begin
            if (c_lda >= NR) m_err = 1'b1;
            else if (c_lda != 0) mq.push_back('{a: c_lda, d: c_ldd});
         end
         if (c_alv && ar) begin
            if (c_ala >= NR) m_err = 1'b1;
            else if (c_ala != 0) mq.push_back('{a: c_ala, d: c_ald});
         end
      end
   endtask

   task automatic mcheck();
      int          free;
      logic [16:0] eb;
      eb = '0;
      free = DEPTH - mq.size();
      foreach (mq[i]) eb[mq[i].a] = 1'b1;
      chk("rnd ld_ready",  bus.ld_ready,  free >= 1);
      chk("rnd alu_ready", bus.alu_ready, (free >= 2) || (free == 1 && !c_ldv));
      chk("rnd wr_en",     bus.wr_en,     (mq.size() > 0) && !c_rst);
      chk("rnd wr_addr",   bus.wr_addr,   (mq.size() > 0) ? mq[0].a : 5'd0);
      chk("rnd wr_data",   bus.wr_data,   (mq.size() > 0) ? mq[0].d : 32'd0);
      chk("rnd busy",      bus.busy,      eb);
      chk("rnd count",     bus.count,     mq.size());
      chk("rnd err",       bus.err,       m_err);
   endtask

   vec_t tbl[22];

   initial begin
      tbl[0]  = mk(0,0,0,       0,0,0,        1,1,0,0,0,          17'h0,     0,0);
      tbl[1]  = mk(0,0,0,       1,3,32'hAB,   1,1,0,0,0,          17'h0,     0,0);
      tbl[2]  = mk(0,0,0,       0,0,0,        1,1,1,3,32'hAB,     17'h8,     1,0);
      tbl[3]  = mk(0,0,0,       0,0,0,        1,1,0,0,0,          17'h0,     0,0);
      tbl[4]  = mk(1,5,7,       1,6,9,        1,1,0,0,0,          17'h0,     0,0);
      tbl[5]  = mk(0,0,0,       0,0,0,        1,1,1,5,7,          17'h60,    2,0);
      tbl[6]  = mk(0,0,0,       0,0,0,        1,1,1,6,9,          17'h40,    1,0);
      tbl[7]  = mk(0,0,0,       0,0,0,        1,1,0,0,0,          17'h0,     0,0);
      tbl[8]  = mk(1,1,1,       1,2,2,        1,1,0,0,0,          17'h0,     0,0);
      tbl[9]  = mk(1,3,3,       1,4,4,        1,1,1,1,1,          17'h6,     2,0);
      tbl[10] = mk(1,7,32'h77,  1,8,32'h88,   1,0,1,2,2,          17'h1C,    3,0);
      tbl[11] = mk(0,0,0,       0,0,0,        1,1,1,3,3,          17'h98,    3,0);
      tbl[12] = mk(0,0,0,       0,0,0,        1,1,1,4,4,          17'h90,    2,0);
      tbl[13] = mk(0,0,0,       0,0,0,        1,1,1,7,32'h77,     17'h80,    1,0);
      tbl[14] = mk(0,0,0,       0,0,0,        1,1,0,0,0,          17'h0,     0,0);
      tbl[15] = mk(1,20,32'h66, 1,0,32'h55,   1,1,0,0,0,          17'h0,     0,0);
      tbl[16] = mk(0,0,0,       0,0,0,        1,1,0,0,0,          17'h0,     0,1);
      tbl[17] = mk(0,0,0,       0,0,0,        1,1,0,0,0,          17'h0,     0,1);
      tbl[18] = mk(0,0,0,       1,16,1022,    1,1,0,0,0,          17'h0,     0,1);
      tbl[19] = mk(0,0,0,       1,16,1021,    1,1,1,16,1022,      17'h10000, 1,1);
      tbl[20] = mk(0,0,0,       0,0,0,        1,1,1,16,1021,      17'h10000, 1,1);
      tbl[21] = mk(0,0,0,       0,0,0,        1,1,0,0,0,          17'h0,     0,1);

      // Reset values
      drive(0,0,0, 0,0,0, 1); commit();
      drive(0,0,0, 0,0,0, 1);
      chk("rst wr_en",   bus.wr_en, 0);     chk("rst wr_addr", bus.wr_addr, 0);
      chk("rst wr_data", bus.wr_data, 0);   chk("rst busy", bus.busy, 0);
      chk("rst count",   bus.count, 0);     chk("rst err", bus.err, 0);
      chk("rst ld_ready", bus.ld_ready, 1); chk("rst alu_ready", bus.alu_ready, 1);
      commit();

      for (int i = 0; i < 22; i++) begin
         drive(tbl[i].ldv, tbl[i].lda, tbl[i].ldd, tbl[i].alv, tbl[i].ala, tbl[i].ald, 0);
         chk($sformatf("vec%0d ld_ready", i),  bus.ld_ready,  tbl[i].ldr);
         chk($sformatf("vec%0d alu_ready", i), bus.alu_ready, tbl[i].alr);
         chk($sformatf("vec%0d wr_en", i),     bus.wr_en,     tbl[i].wr);
         chk($sformatf("vec%0d wr_addr", i),   bus.wr_addr,   tbl[i].wa);
         chk($sformatf("vec%0d wr_data", i),   bus.wr_data,   tbl[i].wd);
         chk($sformatf("vec%0d busy", i),      bus.busy,      tbl[i].busy);
         chk($sformatf("vec%0d count", i),     bus.count,     tbl[i].cnt);
         chk($sformatf("vec%0d err", i),       bus.err,       tbl[i].err);
         commit();
      end

      // Reset with three entries queued (R10, R11, R12 after R9 retires)
      drive(1,9,32'h900,  1,10,32'hA00, 0); commit();
      drive(1,11,32'hB00, 1,12,32'hC00, 0);
      chk("flush pre wr_addr", bus.wr_addr, 9);
      commit();
      drive(0,0,0, 0,0,0, 1);
      chk("flush during count", bus.count, 3);
      chk("flush during wr_en", bus.wr_en, 0);
      commit();
      for (int k = 0; k < 3; k++) begin
         drive(0,0,0, 0,0,0, 0);
         chk("flush post count", bus.count, 0);
         chk("flush post wr_en", bus.wr_en, 0);
         chk("flush post busy",  bus.busy,  0);
         chk("flush post err",   bus.err,   0);
         commit();
      end

      // Random traffic against the queue model
      for (int k = 0; k < 600; k++) begin
         drive(($urandom % 10) < 6, 5'($urandom_range(0, 22)), $urandom,
               ($urandom % 10) < 6, 5'($urandom_range(0, 22)), $urandom,
               ($urandom % 60) == 0);
         mcheck();
         commit();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule : tb_regbank_wb_queue
`default_nettype wire
